dino_motion_ctrl: RTL

Per-frame motion controller for the player dinosaur. Runs on the 50 MHz system clock, takes one step per video frame (falling edge of the VGA vertical sync), and computes the dinosaur's vertical position and pose from the jump/duck buttons and the collision/restart controls. Its `dino_y` and `pose` outputs feed the sprite display stage's dino y-position register and its run/jump/duck/dead sprite selection.

---
 rtl/dino_motion_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl
// Per-frame motion controller for the player dinosaur. It steps once per video
// frame, on the falling edge of the VGA vertical sync, and produces the sprite
// y-position and pose from the jump/duck buttons and the kill/restart controls.
//
// Optional feature: define DINO_FASTFALL_EN for fast-fall. Holding duck while
// airborne triples gravity, and landing with duck held goes straight to DUCK.
//
// Ports
//   clk       in  system clock (same clock as the VGA counters)
//   reset     in  asynchronous, active-high
//   vga_vs_n  in  VGA vertical sync, active-low, same clock domain
//   jump_btn  in  jump request, synchronised level
//   duck_btn  in  duck request, synchronised level
//   kill      in  collision detected, level
//   restart   in  one-cycle pulse that leaves DEAD
//   dino_y    out sprite top-left y
//   pose      out 0 RUN, 1 JUMP, 2 DUCK, 3 DEAD
//   airborne  out high while pose == JUMP
//   upd       out one-cycle strobe the cycle after each frame update
module dino_motion_ctrl #(
  parameter logic [7:0] GROUND_Y = 8'd200,
  parameter logic [7:0] MIN_Y    = 8'd16,
  parameter int         JUMP_V0  = 12,
  parameter int         GRAVITY  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_vs_n,
  input  logic       jump_btn,
  input  logic       duck_btn,
  input  logic       kill,
  input  logic       restart,
  output logic [7:0] dino_y,
  output logic [1:0] pose,
  output logic       airborne,
  output logic       upd
);

  // State codes double as the pose output.
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_JUMP = 2'd1,
    S_DUCK = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  localparam logic signed [6:0] P_V0    = 7'(JUMP_V0);
  localparam logic signed [6:0] P_G     = 7'(GRAVITY);
  localparam logic signed [9:0] P_GND10 = {2'b00, GROUND_Y};
  localparam logic signed [9:0] P_MIN10 = {2'b00, MIN_Y};

  state_t             r_state, w_state_n;
  logic [7:0]         r_y, w_y_n;
  logic signed [6:0]  r_vel, w_vel_n;
  logic               r_pend, w_pend_n;
  logic               r_vs_q, r_jump_q, r_upd, r_air;

  logic               w_tick, w_jedge, w_jreq;
  logic signed [9:0]  w_y_nxt;
  logic signed [6:0]  w_g;
  state_t             w_land_st;

  assign w_tick  = r_vs_q & ~vga_vs_n;
  assign w_jedge = jump_btn & ~r_jump_q;
  // An edge arriving on the tick cycle counts for that tick.
  assign w_jreq  = r_pend | w_jedge;
  // Positive velocity is upward, so the next y subtracts it.
  assign w_y_nxt = $signed({2'b00, r_y}) - $signed({{3{r_vel[6]}}, r_vel});

`ifdef DINO_FASTFALL_EN
  localparam logic signed [6:0] P_G3 = 7'(3 * GRAVITY);
  assign w_g       = duck_btn ? P_G3 : P_G;
  assign w_land_st = duck_btn ? S_DUCK : S_RUN;
`else
  assign w_g       = P_G;
  assign w_land_st = S_RUN;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_y      <= GROUND_Y;
      r_vel    <= '0;
      r_pend   <= 1'b0;
      r_vs_q   <= 1'b1;
      r_jump_q <= 1'b0;
      r_upd    <= 1'b0;
      r_air    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_y      <= w_y_n;
      r_vel    <= w_vel_n;
      r_pend   <= w_pend_n;
      r_vs_q   <= vga_vs_n;
      r_jump_q <= jump_btn;
      r_upd    <= w_tick;
      r_air    <= (w_state_n == S_JUMP);
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_y_n     = r_y;
    w_vel_n   = r_vel;
    w_pend_n  = r_pend | w_jedge;
    if (kill) begin
      // Kill beats both tick and restart; y and vel freeze where they are.
      w_state_n = S_DEAD;
      w_pend_n  = 1'b0;
    end else begin
      case (r_state)
        S_DEAD: begin
          if (restart) begin
            w_state_n = S_RUN;
            w_y_n     = GROUND_Y;
            w_vel_n   = '0;
            w_pend_n  = 1'b0;
          end
        end
        S_RUN, S_DUCK: begin
          if (w_tick) begin
            if (w_jreq) begin
              w_state_n = S_JUMP;
              w_vel_n   = P_V0 - P_G;
              w_y_n     = GROUND_Y - 8'(JUMP_V0);
              w_pend_n  = 1'b0;
            end else begin
              w_state_n = duck_btn ? S_DUCK : S_RUN;
              w_y_n     = GROUND_Y;
            end
          end
        end
        S_JUMP: begin
          if (w_tick) begin
            if ((r_vel <= 7'sd0) && (w_y_nxt >= P_GND10)) begin
              w_state_n = w_land_st;
              w_y_n     = GROUND_Y;
              w_vel_n   = '0;
            end else if (w_y_nxt < P_MIN10) begin
              // Ceiling hit kills all upward speed.
              w_y_n   = MIN_Y;
              w_vel_n = '0;
            end else begin
              w_y_n   = w_y_nxt[7:0];
              w_vel_n = r_vel - w_g;
            end
          end
        end
      endcase
    end
  end

  assign dino_y   = r_y;
  assign pose     = r_state;
  assign airborne = r_air;
  assign upd      = r_upd;

endmodule
